// File: rtl/cmp_event_monitor_pkg.sv
// Shared types for the compare-event monitor: result classes, event record
// layout, monitor FSM states and the flag decoder.
package cmp_event_monitor_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        CMP_NONE = 2'd0,
        CMP_LT   = 2'd1,
        CMP_EQ   = 2'd2,
        CMP_GT   = 2'd3
    } cmp_class_t;

    typedef struct packed {
        cmp_class_t prev;
        cmp_class_t curr;
        data_t      data;
    } cmp_evt_t;

    typedef struct packed {
        cmp_class_t cls;
        logic       illegal;
    } cmp_decode_t;

    typedef enum logic {
        S_UNKNOWN = 1'b0,
        S_STABLE  = 1'b1
    } mon_state_t;

    // Exactly one flag high selects a class; every other pattern is illegal.
    function automatic cmp_decode_t flags_to_class(input logic eq, input logic lt, input logic gt);
        cmp_decode_t d;
        d.cls     = CMP_NONE;
        d.illegal = 1'b0;
        case ({eq, lt, gt})
            3'b100:  d.cls = CMP_EQ;
            3'b010:  d.cls = CMP_LT;
            3'b001:  d.cls = CMP_GT;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cmp_event_monitor_if.sv
// Compare-result input and event-record output channel of the monitor.
interface cmp_event_monitor_if;
    import cmp_event_monitor_pkg::*;

    logic       in_valid;
    logic       equal;
    logic       less;
    logic       greater;
    data_t      in_data;

    logic       evt_valid;
    logic       evt_ready;
    cmp_class_t evt_prev;
    cmp_class_t evt_curr;
    data_t      evt_data;

    modport master (
        output in_valid, equal, less, greater, in_data, evt_ready,
        input  evt_valid, evt_prev, evt_curr, evt_data
    );

    modport slave (
        input  in_valid, equal, less, greater, in_data, evt_ready,
        output evt_valid, evt_prev, evt_curr, evt_data
    );

endinterface

// File: rtl/cmp_event_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module cmp_event_monitor_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at the maximum, clear on rst or clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cmp_event_monitor.sv
// Compare-event monitor: debounces comparator flag classes and emits one
// record per stable-class change on a 1-deep valid/ready output.
module cmp_event_monitor
    import cmp_event_monitor_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    cmp_event_monitor_if.slave bus,
    output cmp_class_t         stable_cls,
    output logic [CNT_W-1:0]   evt_count,
    output logic [CNT_W-1:0]   err_count,
    output logic               overflow
);

    localparam int RUN_W = $clog2(STABLE_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);

    mon_state_t       state;
    mon_state_t       state_nx;
    cmp_class_t       cand;
    cmp_class_t       cand_nx;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nx;
    cmp_decode_t      dec;
    cmp_evt_t         rec;
    cmp_class_t       rec_prev;
    logic             rec_valid;
    logic             legal_smp;
    logic             illegal_smp;
    logic             evt_fire;
    logic             pop;

    assign dec         = flags_to_class(bus.equal, bus.less, bus.greater);
    assign legal_smp   = bus.in_valid & ~dec.illegal;
    assign illegal_smp = bus.in_valid & dec.illegal;
    assign pop         = rec_valid & bus.evt_ready;

    // Run tracking: extend the run on a repeated class, restart it on a new one.
    always_comb begin
        cand_nx = cand;
        run_nx  = run;
        if (legal_smp) begin
            if (dec.cls == cand) begin
                if (run != RUN_MAX) begin
                    run_nx = run + RUN_W'(1);
                end
            end else begin
                cand_nx = dec.cls;
                run_nx  = RUN_W'(1);
            end
        end
    end

    // A full run of a class other than the current stable one is an event.
    assign evt_fire = legal_smp && (run_nx == RUN_MAX) && (cand_nx != stable_cls);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= S_UNKNOWN;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state: the first event makes the monitor stable for good;
    // until then the record reports no previous class.
    always_comb begin
        state_nx = state;
        rec_prev = stable_cls;
        case (state)
            S_UNKNOWN: begin
                rec_prev = CMP_NONE;
                if (evt_fire) begin
                    state_nx = S_STABLE;
                end
            end
            S_STABLE: state_nx = S_STABLE;
            default:  state_nx = S_UNKNOWN;
        endcase
    end

    // Candidate, run length and stable class.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cand       <= CMP_NONE;
            run        <= '0;
            stable_cls <= CMP_NONE;
        end else begin
            cand <= cand_nx;
            run  <= run_nx;
            if (evt_fire) begin
                stable_cls <= cand_nx;
            end
        end
    end

    // 1-deep record buffer: load when free or popped this cycle, otherwise drop
    // the record and remember the loss in the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rec_valid <= 1'b0;
            rec       <= '0;
            overflow  <= 1'b0;
        end else if (evt_fire) begin
            if (!rec_valid || pop) begin
                rec_valid <= 1'b1;
                rec.prev  <= rec_prev;
                rec.curr  <= cand_nx;
                rec.data  <= bus.in_data;
            end else begin
                overflow <= 1'b1;
            end
        end else if (pop) begin
            rec_valid <= 1'b0;
        end
    end

    assign bus.evt_valid = rec_valid;
    assign bus.evt_prev  = rec.prev;
    assign bus.evt_curr  = rec.curr;
    assign bus.evt_data  = rec.data;

    cmp_event_monitor_sat_counter #(.W(CNT_W)) u_evt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (evt_fire),
        .count (evt_count)
    );

    cmp_event_monitor_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (illegal_smp),
        .count (err_count)
    );

endmodule

// File: tb/tb_cmp_event_monitor.sv
// Bench for cmp_event_monitor: two instances (STABLE_CNT 3 and 1) fed the same
// stimulus, each compared every cycle against a history-based reference model.
module tb_cmp_event_monitor;
    import cmp_event_monitor_pkg::*;

    localparam int N_A = 3;
    localparam int W_A = 4;
    localparam int N_B = 1;
    localparam int W_B = 8;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  clear = 1'b0;
    logic  in_valid = 1'b0;
    logic  eq = 1'b0;
    logic  lt = 1'b0;
    logic  gt = 1'b0;
    logic  evt_ready = 1'b1;
    data_t in_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmp_event_monitor_if if_a ();
    cmp_event_monitor_if if_b ();

    assign if_a.in_valid  = in_valid;
    assign if_a.equal     = eq;
    assign if_a.less      = lt;
    assign if_a.greater   = gt;
    assign if_a.in_data   = in_data;
    assign if_a.evt_ready = evt_ready;
    assign if_b.in_valid  = in_valid;
    assign if_b.equal     = eq;
    assign if_b.less      = lt;
    assign if_b.greater   = gt;
    assign if_b.in_data   = in_data;
    assign if_b.evt_ready = evt_ready;

    cmp_class_t     stable_a, stable_b;
    logic [W_A-1:0] ec_a, er_a;
    logic [W_B-1:0] ec_b, er_b;
    logic           ovf_a, ovf_b;

    cmp_event_monitor #(.STABLE_CNT(N_A), .CNT_W(W_A)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .bus(if_a),
        .stable_cls(stable_a), .evt_count(ec_a), .err_count(er_a), .overflow(ovf_a)
    );

    cmp_event_monitor #(.STABLE_CNT(N_B), .CNT_W(W_B)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .bus(if_b),
        .stable_cls(stable_b), .evt_count(ec_b), .err_count(er_b), .overflow(ovf_b)
    );

    // Reference model: remembers the last N legal classes; an event fires when
    // they are all the same class and that class differs from the stable one.
    int          nn[2]    = '{N_A, N_B};
    int          m_max[2] = '{(1 << W_A) - 1, (1 << W_B) - 1};
    int          hist[2][3];
    int          hn[2]       = '{0, 0};
    int          m_stable[2] = '{0, 0};
    int          m_ec[2]     = '{0, 0};
    int          m_er[2]     = '{0, 0};
    bit          m_ovf[2]    = '{0, 0};
    bit          m_valid[2]  = '{0, 0};
    int          m_prev[2]   = '{0, 0};
    int          m_curr[2]   = '{0, 0};
    logic [15:0] m_data[2]   = '{16'h0, 16'h0};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        bit pop;
        bit fire;
        int c;
        int ones;
        pop  = m_valid[k] && evt_ready;
        fire = 1'b0;
        c    = 0;
        if (rst || clear) begin
            hn[k] = 0; m_stable[k] = 0; m_ec[k] = 0; m_er[k] = 0;
            m_ovf[k] = 0; m_valid[k] = 0; m_prev[k] = 0; m_curr[k] = 0; m_data[k] = '0;
            return;
        end
        if (in_valid) begin
            ones = int'(eq) + int'(lt) + int'(gt);
            if (ones != 1) begin
                if (m_er[k] < m_max[k]) m_er[k]++;
            end else begin
                c = eq ? 2 : (lt ? 1 : 3);
                if (hn[k] < nn[k]) begin
                    hist[k][hn[k]] = c;
                    hn[k]++;
                end else begin
                    for (int i = 0; i < nn[k] - 1; i++) hist[k][i] = hist[k][i+1];
                    hist[k][nn[k]-1] = c;
                end
                fire = (hn[k] == nn[k]) && (c != m_stable[k]);
                for (int i = 0; i < hn[k]; i++) if (hist[k][i] != c) fire = 1'b0;
            end
        end
        if (fire) begin
            if (!m_valid[k] || pop) begin
                m_valid[k] = 1'b1;
                m_prev[k]  = m_stable[k];
                m_curr[k]  = c;
                m_data[k]  = in_data;
            end else begin
                m_ovf[k] = 1'b1;
            end
            m_stable[k] = c;
            if (m_ec[k] < m_max[k]) m_ec[k]++;
        end else if (pop) begin
            m_valid[k] = 1'b0;
        end
    endtask

    // Advance the model on the same edge the DUTs sample their inputs.
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Compare both instances against the model away from the active edge.
    always @(negedge clk) begin
        check("a_evt_valid", if_a.evt_valid, m_valid[0]);
        if (m_valid[0]) begin
            check("a_evt_prev", if_a.evt_prev, m_prev[0]);
            check("a_evt_curr", if_a.evt_curr, m_curr[0]);
            check("a_evt_data", if_a.evt_data, m_data[0]);
        end
        check("a_stable", stable_a, m_stable[0]);
        check("a_evt_count", ec_a, m_ec[0]);
        check("a_err_count", er_a, m_er[0]);
        check("a_overflow", ovf_a, m_ovf[0]);
        check("b_evt_valid", if_b.evt_valid, m_valid[1]);
        if (m_valid[1]) begin
            check("b_evt_prev", if_b.evt_prev, m_prev[1]);
            check("b_evt_curr", if_b.evt_curr, m_curr[1]);
            check("b_evt_data", if_b.evt_data, m_data[1]);
        end
        check("b_stable", stable_b, m_stable[1]);
        check("b_evt_count", ec_b, m_ec[1]);
        check("b_err_count", er_b, m_er[1]);
        check("b_overflow", ovf_b, m_ovf[1]);
    end

    task automatic drive(input bit v, input bit e, input bit l, input bit g, input logic [15:0] d);
        in_valid = v; eq = e; lt = l; gt = g; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input int c, input logic [15:0] d);
        drive(1'b1, c == 2, c == 1, c == 3, d);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    int n_evt;
    int cur_cls;
    int pat;

    initial begin
        idle();
        idle();
        rst = 1'b0;

        // reset state
        check("lit_rst_valid", if_a.evt_valid, 0);
        check("lit_rst_stable", stable_a, CMP_NONE);
        check("lit_rst_evt_count", ec_a, 0);
        check("lit_rst_err_count", er_a, 0);
        check("lit_rst_overflow", ovf_a, 0);

        // first stable class LT
        smp(1, 16'h0011);
        check("lit_b_first_valid", if_b.evt_valid, 1);
        check("lit_b_first_curr", if_b.evt_curr, CMP_LT);
        check("lit_b_first_prev", if_b.evt_prev, CMP_NONE);
        smp(1, 16'h0012);
        check("lit_t1_no_early", if_a.evt_valid, 0);
        smp(1, 16'h0013);
        check("lit_t1_valid", if_a.evt_valid, 1);
        check("lit_t1_prev", if_a.evt_prev, CMP_NONE);
        check("lit_t1_curr", if_a.evt_curr, CMP_LT);
        check("lit_t1_data", if_a.evt_data, 16'h0013);
        check("lit_t1_stable", stable_a, CMP_LT);
        check("lit_t1_evt_count", ec_a, 1);
        idle();

        // interrupted GT run: exactly one event, on the sixth sample
        n_evt = 0;
        for (int i = 0; i < 6; i++) begin
            smp((i == 2) ? 1 : 3, 16'h0020 + 16'(i));
            if (if_a.evt_valid) n_evt++;
            if (i == 0) begin
                check("lit_b_gt_valid", if_b.evt_valid, 1);
                check("lit_b_gt_prev", if_b.evt_prev, CMP_LT);
            end
        end
        check("lit_t2_events", n_evt, 1);
        check("lit_t2_prev", if_a.evt_prev, CMP_LT);
        check("lit_t2_curr", if_a.evt_curr, CMP_GT);
        check("lit_t2_data", if_a.evt_data, 16'h0025);
        check("lit_t2_evt_count", ec_a, 2);
        idle();

        // idle gaps do not break a run
        smp(1, 16'h0030);
        idle();
        idle();
        smp(1, 16'h0031);
        check("lit_t3_no_early", if_a.evt_valid, 0);
        idle();
        smp(1, 16'h0032);
        check("lit_t3_valid", if_a.evt_valid, 1);
        check("lit_t3_curr", if_a.evt_curr, CMP_LT);
        check("lit_t3_prev", if_a.evt_prev, CMP_GT);
        idle();

        // illegal flags inside an EQ run
        smp(2, 16'h0040);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h00ee);
        smp(2, 16'h0041);
        check("lit_t4_no_early", if_a.evt_valid, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h00ef);
        smp(2, 16'h0042);
        check("lit_t4_err_count", er_a, 2);
        check("lit_t4_valid", if_a.evt_valid, 1);
        check("lit_t4_curr", if_a.evt_curr, CMP_EQ);
        check("lit_t4_data", if_a.evt_data, 16'h0042);

        // full output: second event dropped, first held
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) smp(3, 16'h0050 + 16'(i));
        for (int i = 0; i < 3; i++) smp(1, 16'h0053 + 16'(i));
        check("lit_t5_valid", if_a.evt_valid, 1);
        check("lit_t5_curr", if_a.evt_curr, CMP_GT);
        check("lit_t5_data", if_a.evt_data, 16'h0052);
        check("lit_t5_overflow", ovf_a, 1);
        check("lit_t5_evt_count", ec_a, 2);
        check("lit_t5_stable", stable_a, CMP_LT);
        evt_ready = 1'b1;
        idle();
        check("lit_t5_popped", if_a.evt_valid, 0);
        check("lit_t5_sticky", ovf_a, 1);

        // clear wins over an event-completing sample
        do_reset();
        smp(2, 16'h0060);
        smp(2, 16'h0061);
        clear = 1'b1;
        smp(2, 16'h0062);
        clear = 1'b0;
        check("lit_t6_valid", if_a.evt_valid, 0);
        check("lit_t6_stable", stable_a, CMP_NONE);
        check("lit_t6_evt_count", ec_a, 0);
        check("lit_t6_b_valid", if_b.evt_valid, 0);
        check("lit_t6_b_stable", stable_b, CMP_NONE);

        // randomized traffic
        cur_cls = 1;
        for (int i = 0; i < 3000; i++) begin
            evt_ready = ($urandom_range(0, 9) < 7);
            clear     = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) cur_cls = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else if ($urandom_range(0, 11) == 0) begin
                pat = $urandom_range(0, 4);
                case (pat)
                    0: drive(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
                    1: drive(1'b1, 1'b0, 1'b1, 1'b1, 16'($urandom));
                    2: drive(1'b1, 1'b1, 1'b0, 1'b1, 16'($urandom));
                    3: drive(1'b1, 1'b1, 1'b1, 1'b0, 16'($urandom));
                    default: drive(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom));
                endcase
            end else begin
                smp(cur_cls, 16'($urandom));
            end
        end
        clear = 1'b0;
        evt_ready = 1'b1;
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
